// File: rtl/rptr_empty.sv
// Read-domain pointer and empty/level generator for the asynchronous FIFO.
// Consumes the synchronized write Gray pointer and publishes the read Gray pointer.
module rptr_empty #(
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input  logic                  RCLK,
    input  logic                  RRST,
    input  logic                  REN,
    input  logic [ADDR_WIDTH:0]   wp2_rpt,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rpt,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rvalid,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          ren_ok;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ren_ok     = REN & ~empty;
        rbin_next  = rbin + PW'(ren_ok);
        rgray_next = rbin_next ^ (rbin_next >> 1);
        wbin       = '0;
        // Bit i of the binary pointer is the XOR of all Gray bits at or above i.
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(wp2_rpt >> i);
        end
        level_next = wbin - rbin_next;
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge RCLK) begin
        if (RRST) begin
            rbin         <= '0;
            rpt          <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rvalid       <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rpt          <= rgray_next;
            empty        <= (rgray_next == wp2_rpt);
            almost_empty <= (level_next <= AE_LVL);
            rd_level     <= level_next;
            rvalid       <= ren_ok;
            if (REN && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty: vector table plus model-driven scoreboard
// for drain, wrap and mid-operation reset sequences.
module tb_rptr_empty;

    logic       RCLK;
    logic       RRST;
    logic       REN;
    logic [4:0] wp2_rpt;
    logic [3:0] raddr;
    logic [4:0] rpt;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       rvalid;
    logic       underflow;

    rptr_empty #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
        .RCLK(RCLK), .RRST(RRST), .REN(REN), .wp2_rpt(wp2_rpt),
        .raddr(raddr), .rpt(rpt), .empty(empty), .almost_empty(almost_empty),
        .rd_level(rd_level), .rvalid(rvalid), .underflow(underflow)
    );

    initial RCLK = 1'b0;
    always #5 RCLK = ~RCLK;

    typedef struct {
        logic [4:0] rpt;
        logic [3:0] raddr;
        logic       empty;
        logic       ae;
        logic [4:0] level;
        logic       rvalid;
        logic       uf;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       ren;
        logic [4:0] wp;
        exp_t       e;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    exp_t sb_q[$];

    // Reference model state
    logic [4:0] m_rbin  = '0;
    logic       m_empty = 1'b1;
    logic       m_uf    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    // Drive one cycle, predict post-edge outputs, compare them after the edge.
    task automatic step(input logic rst, input logic ren, input logic [4:0] wp);
        exp_t e;
        exp_t got;
        logic ok;
        logic [4:0] nb;
        RRST = rst; REN = ren; wp2_rpt = wp;
        if (rst) begin
            m_rbin = '0; m_empty = 1'b1; m_uf = 1'b0;
            e = '{rpt: 5'd0, raddr: 4'd0, empty: 1'b1, ae: 1'b1, level: 5'd0, rvalid: 1'b0, uf: 1'b0};
        end else begin
            ok       = ren && !m_empty;
            nb       = m_rbin + (ok ? 5'd1 : 5'd0);
            e.rpt    = gray(int'(nb));
            e.raddr  = nb[3:0];
            e.level  = g2b(wp) - nb;
            e.ae     = (e.level <= 5'd2);
            e.empty  = (e.rpt == wp);
            e.rvalid = ok;
            m_uf     = m_uf | (ren & m_empty);
            e.uf     = m_uf;
            m_rbin   = nb;
            m_empty  = e.empty;
        end
        sb_q.push_back(e);
        @(posedge RCLK);
        #1;
        got = sb_q.pop_front();
        check("sb_rpt",    32'(rpt),          32'(got.rpt));
        check("sb_raddr",  32'(raddr),        32'(got.raddr));
        check("sb_empty",  32'(empty),        32'(got.empty));
        check("sb_ae",     32'(almost_empty), 32'(got.ae));
        check("sb_level",  32'(rd_level),     32'(got.level));
        check("sb_rvalid", 32'(rvalid),       32'(got.rvalid));
        check("sb_uf",     32'(underflow),    32'(got.uf));
    endtask

    vec_t vt[8];
    int   rv_cnt;

    initial begin
        vt[0] = '{1'b1, 1'b1, 5'b00011, '{5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0}};
        vt[1] = '{1'b1, 1'b1, 5'b00011, '{5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0}};
        vt[2] = '{1'b0, 1'b0, 5'b00001, '{5'b00000, 4'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0}};
        vt[3] = '{1'b0, 1'b1, 5'b00001, '{5'b00001, 4'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0}};
        vt[4] = '{1'b0, 1'b1, 5'b00001, '{5'b00001, 4'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1}};
        vt[5] = '{1'b0, 1'b0, 5'b00011, '{5'b00001, 4'd1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1}};
        vt[6] = '{1'b0, 1'b1, 5'b00011, '{5'b00011, 4'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1}};
        vt[7] = '{1'b1, 1'b0, 5'b00011, '{5'b00000, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0}};

        RRST = 1'b1; REN = 1'b0; wp2_rpt = '0;
        #2;

        // Reset, single item, underflow, sticky underflow, reset clears it
        for (int i = 0; i < 8; i++) begin
            step(vt[i].rst, vt[i].ren, vt[i].wp);
            check($sformatf("vec%0d_rpt", i),    32'(rpt),          32'(vt[i].e.rpt));
            check($sformatf("vec%0d_raddr", i),  32'(raddr),        32'(vt[i].e.raddr));
            check($sformatf("vec%0d_empty", i),  32'(empty),        32'(vt[i].e.empty));
            check($sformatf("vec%0d_ae", i),     32'(almost_empty), 32'(vt[i].e.ae));
            check($sformatf("vec%0d_level", i),  32'(rd_level),     32'(vt[i].e.level));
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid),       32'(vt[i].e.rvalid));
            check($sformatf("vec%0d_uf", i),     32'(underflow),    32'(vt[i].e.uf));
        end

        // Full FIFO then drain with REN held high
        step(1'b0, 1'b0, 5'b11000);
        check("full_level", 32'(rd_level),     32'd16);
        check("full_empty", 32'(empty),        32'd0);
        check("full_ae",    32'(almost_empty), 32'd0);
        rv_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            check("drain_raddr", 32'(raddr), 32'(i));
            step(1'b0, 1'b1, 5'b11000);
            if (rvalid) rv_cnt++;
            if (i == 12) check("drain_ae_lvl3", 32'(almost_empty), 32'd0);
            if (i == 13) check("drain_ae_lvl2", 32'(almost_empty), 32'd1);
        end
        check("drain_rvalid_cnt", 32'(rv_cnt), 32'd16);
        check("drain_empty",      32'(empty),  32'd1);
        check("drain_rpt",        32'(rpt),    32'b11000);
        step(1'b0, 1'b0, 5'b11000);
        check("drain_rvalid_end", 32'(rvalid), 32'd0);

        // Wrap: write pointer leads by 3, read 16 more to wrap 31 -> 0
        step(1'b0, 1'b0, gray(19));
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check("wrap_rpt_pre", 32'(rpt), 32'b10000);
            step(1'b0, 1'b1, gray(16 + k + 3));
        end
        check("wrap_rpt",   32'(rpt),      32'b00000);
        check("wrap_raddr", 32'(raddr),    32'd0);
        check("wrap_level", 32'(rd_level), 32'd2);
        check("wrap_empty", 32'(empty),    32'd0);

        // Reset in the middle of activity
        step(1'b0, 1'b0, gray(5));
        check("mid_level", 32'(rd_level), 32'd5);
        step(1'b1, 1'b1, gray(5));
        check("mid_rst_level",  32'(rd_level), 32'd0);
        check("mid_rst_empty",  32'(empty),    32'd1);
        check("mid_rst_rvalid", 32'(rvalid),   32'd0);
        check("mid_rst_rpt",    32'(rpt),      32'd0);
        step(1'b0, 1'b0, gray(5));
        check("mid_post_rvalid", 32'(rvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
